// File: rtl/pipelined_control.sv
// WISC pipeline control unit: ID-stage decode, load-use hazard bubbles,
// downstream stall/flush handling and a sticky halt, registered into ID/EX.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid            ID holds a valid instruction
//   id_opcode           instruction[15:12]
//   id_rd/id_rs/id_rt   register specifiers instruction[11:8]/[7:4]/[3:0]
//   ex_stall            EX cannot accept; ID/EX holds
//   flush               branch taken; instruction entering EX is killed
//   id_ready            ID instruction consumed this cycle (combinational)
//   ex_valid            EX slot holds a real instruction
//   ex_*                registered control bits, ALU op and destination
//   halted              sticky halt, cleared only by rst
module pipelined_control #(
    parameter int OPC_W    = 4,
    parameter int ALUOP_W  = 3,
    parameter int RADDR_W  = 4,
    parameter int ZERO_REG = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OPC_W-1:0]   id_opcode,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               ex_stall,
    input  logic               flush,
    output logic               id_ready,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic               ex_mem,
    output logic               ex_modify,
    output logic               ex_branch,
    output logic               ex_branch_reg,
    output logic               ex_pcs,
    output logic               ex_halt,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [RADDR_W-1:0] ex_dst,
    output logic               halted
);

    typedef struct packed {
        logic               reg_write;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               mem;
        logic               modify;
        logic               branch;
        logic               branch_reg;
        logic               pcs;
        logic               halt;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    ctrl_t              dec;
    logic               use_rs;
    logic               use_rt;
    logic               use_rd;
    logic               op_ok;
    logic [3:0]         op4;

    logic               ex_valid_q, ex_valid_d;
    ctrl_t              ex_ctrl_q, ex_ctrl_d;
    logic [RADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic               halted_q, halted_d;

    logic               dst_live;
    logic               src_hit;
    logic               hazard;

    // Opcode bits above [3:0] must be zero, otherwise the word is a NOP.
    assign op_ok = ((id_opcode >> 4) == '0);
    assign op4   = id_opcode[3:0];

    always_comb begin
        dec    = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        if (op_ok) begin
            case (op4)
                4'b0000, 4'b0001, 4'b0010,
                4'b0011, 4'b0111: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALUOP_W'(op4[2:0]);
                    use_rs        = 1'b1;
                    use_rt        = 1'b1;
                end
                // Shifts/rotate: rt field is an immediate.
                4'b0100, 4'b0101, 4'b0110: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALUOP_W'(op4[2:0]);
                    use_rs        = 1'b1;
                end
                4'b1000: begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.mem        = 1'b1;
                    use_rs         = 1'b1;
                end
                // Store data comes from the rd field.
                4'b1001: begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.mem       = 1'b1;
                    use_rs        = 1'b1;
                    use_rd        = 1'b1;
                end
                // LLB/LHB read-modify-write rd.
                4'b1010, 4'b1011: begin
                    dec.modify    = 1'b1;
                    dec.reg_write = 1'b1;
                    use_rd        = 1'b1;
                end
                4'b1100: begin
                    dec.branch = 1'b1;
                end
                4'b1101: begin
                    dec.branch     = 1'b1;
                    dec.branch_reg = 1'b1;
                    use_rs         = 1'b1;
                end
                4'b1110: begin
                    dec.pcs       = 1'b1;
                    dec.reg_write = 1'b1;
                end
                default: begin
                    dec.halt = 1'b1;
                end
            endcase
        end
    end

    assign dst_live = (ex_dst_q != RADDR_W'(ZERO_REG));
    assign src_hit  = (use_rs && (id_rs == ex_dst_q))
                    | (use_rt && (id_rt == ex_dst_q))
                    | (use_rd && (id_rd == ex_dst_q));
    assign hazard   = id_valid & ex_valid_q & ex_ctrl_q.mem_to_reg
                    & dst_live & src_hit;

    // A flushed ID instruction is discarded, so fetch may advance.
    assign id_ready = flush
                    | (~rst & ~halted_q & ~ex_stall & ~hazard);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_dst_d   = ex_dst_q;
        halted_d   = halted_q
                   | (ex_valid_q & ex_ctrl_q.halt & ~ex_stall & ~flush);
        // Stall beats hazard: no bubble while held.
        if (flush || halted_q || (!ex_stall && hazard)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_dst_d   = '0;
        end else if (!ex_stall) begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_valid ? dec : '0;
            ex_dst_d   = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_dst_q   <= '0;
            halted_q   <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_dst_q   <= ex_dst_d;
            halted_q   <= halted_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_mem        = ex_ctrl_q.mem;
    assign ex_modify     = ex_ctrl_q.modify;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_branch_reg = ex_ctrl_q.branch_reg;
    assign ex_pcs        = ex_ctrl_q.pcs;
    assign ex_halt       = ex_ctrl_q.halt;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_dst        = ex_dst_q;
    assign halted        = halted_q;

endmodule
